pulse_emitter: RTL and testbench

Transmit-side counterpart of the pulse capture path: turns single-cycle trigger strobes into timed, fixed-width pulses on an output pin, e.g. a bank-16 IO looped back to the capture input.
- Requests arriving while a pulse is in flight are queued in a saturating pending counter and emitted back-to-back.
- Sits behind the clock wizard and a posedge_detector (button or internal event) and drives the output pin directly from a flop.

---
 rtl/pulse_emitter.sv | 175 +++++++++++++++++
 tb/tb_pulse_emitter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_emitter.sv
// pulse_emitter: turns single-cycle trigger strobes into fixed-width pulses.
// Requests that arrive while a pulse is in flight are queued in a saturating
// pending counter and emitted back-to-back with a minimum low gap.
// Optional build macro: PULSE_EMITTER_DELAY_EN adds a leading DELAY phase
// of DELAY_CYCLES before every pulse.
module pulse_emitter #(
  parameter int HIGH_CYCLES  = 100_000_000,
  parameter int LOW_CYCLES   = 50_000_000,
  parameter int MAX_PENDING  = 15,
  parameter int DELAY_CYCLES = 100_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               trigger,
  input  logic                               abort,
  output logic                               pulse_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  localparam int PW   = $clog2(MAX_PENDING + 1);
  localparam int CMAX = max3(HIGH_CYCLES, LOW_CYCLES, DELAY_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  // Counter reload values: the counter runs from N-1 down to 0, giving N cycles.
  localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PENDING);
`ifdef PULSE_EMITTER_DELAY_EN
  localparam logic [CW-1:0] DELAY_LD = CW'(DELAY_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2
`ifdef PULSE_EMITTER_DELAY_EN
    ,
    DELAY = 2'd3
`endif
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic [PW-1:0]   pending_r;
  logic [PW-1:0]   pending_next_s;
  logic            launch_s;
  logic            inc_s;
  logic            drop_s;
  logic            pulse_r;
  logic            busy_r;
  logic            overflow_r;
  logic            has_pending_s;

  assign has_pending_s = (pending_r != {PW{1'b0}});

  // Next-state and counter reload logic; a launch consumes one queued request.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    launch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (has_pending_s) begin
          launch_s = 1'b1;
`ifdef PULSE_EMITTER_DELAY_EN
          next_state_s = DELAY;
          cnt_next_s   = DELAY_LD;
`else
          next_state_s = HIGH;
          cnt_next_s   = HIGH_LD;
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
`ifdef PULSE_EMITTER_DELAY_EN
      DELAY: begin
        if (cnt_r == {CW{1'b0}}) begin
          next_state_s = HIGH;
          cnt_next_s   = HIGH_LD;
        end else begin
          cnt_next_s = cnt_r - CW'(1);
        end
      end
`endif
      HIGH: begin
        if (cnt_r == {CW{1'b0}}) begin
          next_state_s = LOW;
          cnt_next_s   = LOW_LD;
        end else begin
          cnt_next_s = cnt_r - CW'(1);
        end
      end
      LOW: begin
        if (cnt_r == {CW{1'b0}}) begin
          if (has_pending_s) begin
            launch_s = 1'b1;
`ifdef PULSE_EMITTER_DELAY_EN
            next_state_s = DELAY;
            cnt_next_s   = DELAY_LD;
`else
            next_state_s = HIGH;
            cnt_next_s   = HIGH_LD;
`endif
          end else begin
            next_state_s = IDLE;
            cnt_next_s   = {CW{1'b0}};
          end
        end else begin
          cnt_next_s = cnt_r - CW'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Saturating pending counter: a launch frees a slot in the same cycle, so a
  // trigger coinciding with a launch is always accepted.
  always_comb begin
    inc_s  = trigger && ((pending_r < MAX_P) || launch_s);
    drop_s = trigger && !inc_s;
    case ({inc_s, launch_s})
      2'b10:   pending_next_s = pending_r + PW'(1);
      2'b01:   pending_next_s = pending_r - PW'(1);
      default: pending_next_s = pending_r;
    endcase
  end

  // State, counter and output flops; rst beats abort, abort keeps overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      pending_r  <= {PW{1'b0}};
      pulse_r    <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (abort) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      pending_r  <= {PW{1'b0}};
      pulse_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= cnt_next_s;
      pending_r  <= pending_next_s;
      pulse_r    <= (next_state_s == HIGH);
      busy_r     <= (next_state_s != IDLE);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign pulse_out = pulse_r;
  assign busy      = busy_r;
  assign pending   = pending_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_pulse_emitter.sv
// Self-checking bench for pulse_emitter (HIGH=4, LOW=3, MAX_PENDING=3,
// DELAY=2). Per-cycle vectors carry inputs and expected outputs taken from
// the documented timelines; each is pushed to a scoreboard when driven and
// popped/compared when the outputs are sampled on the falling edge.
module tb_pulse_emitter;

  localparam int HC = 4;
  localparam int LC = 3;
  localparam int MP = 3;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic       abort = 1'b0;
  logic       pulse_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  pulse_emitter #(
    .HIGH_CYCLES (HC),
    .LOW_CYCLES  (LC),
    .MAX_PENDING (MP),
    .DELAY_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .abort    (abort),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  typedef struct {
    int         sid;
    int         cyc;
    logic       pre_rst;
    logic       trig;
    logic       ab;
    logic       rs;
    logic       e_pulse;
    logic       e_busy;
    logic [1:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses_c = 0;
  logic last_pulse = 1'b0;

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic add(input int sid, input int cyc, input logic pr, input logic tr,
                     input logic ab, input logic rs, input logic p, input logic b,
                     input logic [1:0] pd, input logic ov);
    vec_t v;
    v.sid = sid; v.cyc = cyc; v.pre_rst = pr; v.trig = tr; v.ab = ab; v.rs = rs;
    v.e_pulse = p; v.e_busy = b; v.e_pend = pd; v.e_ovf = ov;
    vecs.push_back(v);
  endtask

  task automatic check(input int sid, input int cyc, input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL s%0d c%0d %s got %0d expected %0d", sid, cyc, name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    trigger = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] pd;

`ifdef PULSE_EMITTER_DELAY_EN
    // Single trigger with a 2-cycle leading delay.
    for (int c = 0; c <= 14; c++)
      add(1, c, c == 0, c == 0, 1'b0, 1'b0, in_rng(c, 4, 7), in_rng(c, 2, 10),
          (c == 1) ? 2'd1 : 2'd0, 1'b0);
`else
    // A: single trigger.
    for (int c = 0; c <= 11; c++)
      add(1, c, c == 0, c == 0, 1'b0, 1'b0, in_rng(c, 2, 5), in_rng(c, 2, 8),
          (c == 1) ? 2'd1 : 2'd0, 1'b0);
    // B: three triggers queued back-to-back.
    for (int c = 0; c <= 25; c++) begin
      if (c == 1 || c == 2)      pd = 2'd1;
      else if (in_rng(c, 3, 8))  pd = 2'd2;
      else if (in_rng(c, 9, 15)) pd = 2'd1;
      else                       pd = 2'd0;
      add(2, c, c == 0, c <= 2, 1'b0, 1'b0,
          in_rng(c, 2, 5) || in_rng(c, 9, 12) || in_rng(c, 16, 19),
          in_rng(c, 2, 22), pd, 1'b0);
    end
    // C: five triggers, saturation at 3 and sticky overflow.
    for (int c = 0; c <= 32; c++) begin
      if (c == 1 || c == 2)       pd = 2'd1;
      else if (c == 3)            pd = 2'd2;
      else if (in_rng(c, 4, 8))   pd = 2'd3;
      else if (in_rng(c, 9, 15))  pd = 2'd2;
      else if (in_rng(c, 16, 22)) pd = 2'd1;
      else                        pd = 2'd0;
      add(3, c, c == 0, c <= 4, 1'b0, 1'b0,
          in_rng(c, 2, 5) || in_rng(c, 9, 12) || in_rng(c, 16, 19) || in_rng(c, 23, 26),
          in_rng(c, 2, 29), pd, c >= 5);
    end
    // D: abort mid-pulse with a coincident trigger; overflow left at 1.
    for (int c = 0; c <= 12; c++)
      add(4, c, 1'b0, (c == 0) || (c == 3), c == 3, 1'b0, in_rng(c, 2, 3),
          in_rng(c, 2, 3), (c == 1) ? 2'd1 : 2'd0, 1'b1);
    // E: rst with two requests queued, then a fresh trigger at cycle 8.
    for (int c = 0; c <= 18; c++) begin
      if (c == 1 || c == 2 || c == 9) pd = 2'd1;
      else if (c == 3)                pd = 2'd2;
      else                            pd = 2'd0;
      add(5, c, c == 0, (c <= 2) || (c == 8), 1'b0, c == 3,
          in_rng(c, 2, 3) || in_rng(c, 10, 13),
          in_rng(c, 2, 3) || in_rng(c, 10, 16), pd, 1'b0);
    end
`endif

    foreach (vecs[i]) begin
      vec_t v;
      vec_t e;
      v = vecs[i];
      if (v.pre_rst) begin
        do_reset();
      end else begin
        @(posedge clk);
        #1;
      end
      trigger = v.trig;
      abort   = v.ab;
      rst     = v.rs;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      check(e.sid, e.cyc, "pulse_out", int'(pulse_out), int'(e.e_pulse));
      check(e.sid, e.cyc, "busy",      int'(busy),      int'(e.e_busy));
      check(e.sid, e.cyc, "pending",   int'(pending),   int'(e.e_pend));
      check(e.sid, e.cyc, "overflow",  int'(overflow),  int'(e.e_ovf));
      if (e.sid == 3) begin
        if (pulse_out && !last_pulse) pulses_c++;
        last_pulse = pulse_out;
      end
    end

`ifndef PULSE_EMITTER_DELAY_EN
    // Saturated queue: the first pulse plus three queued ones, nothing more.
    check(3, 32, "pulse_count", pulses_c, 4);
`endif

    @(posedge clk);
    #1;
    trigger = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
